multicycle_shifter: RTL and testbench

//  Parametrised multi-cycle shift unit for the LEGv8 datapath; supersedes the fixed

---
 rtl/multicycle_shifter.sv | 129 ++++++++++++
 tb/tb_multicycle_shifter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_shifter.sv
// multicycle_shifter: LSL/LSR/ASR/ROR by a variable amount, at most STEP bits per clock.
// Define SHIFTER_CARRY_EN to add the carry_out port (last bit shifted out).
module multicycle_shifter #(
    parameter int DATA_WIDTH = 64,
    parameter int STEP = 8,
    localparam int AMT_W = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0]      in_amt,
    input  logic [1:0]            in_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
`ifdef SHIFTER_CARRY_EN
    ,
    output logic                  carry_out
`endif
);
    // One extra bit so STEP and DATA_WIDTH are both representable as shift distances
    localparam int SW = AMT_W + 1;
    localparam logic [SW-1:0] STEP_S = SW'(STEP);
    localparam logic [SW-1:0] WIDTH_S = SW'(DATA_WIDTH);
    localparam logic [1:0] M_LSL = 2'b00;
    localparam logic [1:0] M_LSR = 2'b01;
    localparam logic [1:0] M_ASR = 2'b10;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] work_q, work_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [AMT_W-1:0]      rem_q, rem_d;
    logic [1:0]            mode_q, mode_d;
    logic [SW-1:0]         step_s;
    logic [AMT_W-1:0]      rem_next;
    logic [DATA_WIDTH-1:0] lsl_v, lsr_v, asr_v, ror_v, shifted;
`ifdef SHIFTER_CARRY_EN
    logic                  carry_q, carry_d, carry_bit;
    logic [AMT_W-1:0]      s_a, lsl_idx, rsh_idx;
`endif

    always_comb begin
        step_s   = ({1'b0, rem_q} < STEP_S) ? {1'b0, rem_q} : STEP_S;
        rem_next = rem_q - AMT_W'(step_s);
        lsl_v    = work_q << step_s;
        lsr_v    = work_q >> step_s;
        asr_v    = $signed(work_q) >>> step_s;
        // Shift by DATA_WIDTH yields zero, so s=0 leaves the rotate unchanged
        ror_v    = lsr_v | (work_q << (WIDTH_S - step_s));
        shifted  = (mode_q == M_LSL) ? lsl_v :
                   (mode_q == M_LSR) ? lsr_v :
                   (mode_q == M_ASR) ? asr_v : ror_v;
    end

`ifdef SHIFTER_CARRY_EN
    // LSL loses bit W-s; right shifts and rotate all lose (or wrap) bit s-1
    always_comb begin
        s_a       = AMT_W'(step_s);
        lsl_idx   = AMT_W'(0) - s_a;
        rsh_idx   = s_a - AMT_W'(1);
        carry_bit = (mode_q == M_LSL) ? work_q[lsl_idx] : work_q[rsh_idx];
    end
`endif

    always_comb begin
        state_d    = state_q;
        work_d     = work_q;
        out_data_d = out_data_q;
        rem_d      = rem_q;
        mode_d     = mode_q;
`ifdef SHIFTER_CARRY_EN
        carry_d    = carry_q;
`endif
        if (state_q == IDLE && in_valid) begin
            state_d = BUSY;
            work_d  = in_data;
            mode_d  = in_mode;
            rem_d   = in_amt;
`ifdef SHIFTER_CARRY_EN
            carry_d = 1'b0;
`endif
        end else if (state_q == BUSY) begin
            work_d = shifted;
            rem_d  = rem_next;
`ifdef SHIFTER_CARRY_EN
            carry_d = (step_s != '0) ? carry_bit : carry_q;
`endif
            if (rem_next == '0) begin
                state_d    = DONE;
                out_data_d = shifted;
            end
        end else if (state_q == DONE && out_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            work_q     <= '0;
            out_data_q <= '0;
            rem_q      <= '0;
            mode_q     <= '0;
`ifdef SHIFTER_CARRY_EN
            carry_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            work_q     <= work_d;
            out_data_q <= out_data_d;
            rem_q      <= rem_d;
            mode_q     <= mode_d;
`ifdef SHIFTER_CARRY_EN
            carry_q    <= carry_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = out_data_q;
`ifdef SHIFTER_CARRY_EN
    assign carry_out = carry_q;
`endif
endmodule

// File: tb/tb_multicycle_shifter.sv
// tb_multicycle_shifter: directed checks of multicycle_shifter (64-bit, STEP 8).
module tb_multicycle_shifter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = '0;
    logic [5:0]  in_amt = '0;
    logic [1:0]  in_mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_data;
    logic        carry_out;
    int          n_checks = 0;
    int          n_fail = 0;
    int          lat;

    multicycle_shifter #(.DATA_WIDTH(64), .STEP(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_amt(in_amt), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef SHIFTER_CARRY_EN
        , .carry_out(carry_out)
`endif
    );

`ifndef SHIFTER_CARRY_EN
    assign carry_out = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic [63:0] d, input logic [5:0] a, input logic [1:0] m,
                         output int l);
        int w = 0;
        @(negedge clk);
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = a;
        in_mode  = m;
        @(posedge clk);
        #1 in_valid = 1'b0;
        l = 0;
        while (!out_valid && l < 100) begin
            @(posedge clk);
            #1 l++;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_carry", 64'(carry_out), 64'd0);
        @(negedge clk) reset = 1'b0;
        #1 check("rst_in_ready", 64'(in_ready), 64'd1);

        do_op(64'h1, 6'd2, 2'b00, lat);
        check("lsl2_lat", 64'(lat), 64'd1);
        check("lsl2_data", out_data, 64'h4);
        check("lsl2_in_ready", 64'(in_ready), 64'd0);

        do_op(64'h8000_0000_0000_0000, 6'd63, 2'b01, lat);
        check("lsr63_lat", 64'(lat), 64'd8);
        check("lsr63_data", out_data, 64'h1);
`ifdef SHIFTER_CARRY_EN
        check("lsr63_carry", 64'(carry_out), 64'd0);
`endif

        do_op(64'h8000_0000_0000_0000, 6'd4, 2'b10, lat);
        check("asr4_lat", 64'(lat), 64'd1);
        check("asr4_data", out_data, 64'hF800_0000_0000_0000);

        do_op(64'h1, 6'd1, 2'b11, lat);
        check("ror1_data", out_data, 64'h8000_0000_0000_0000);
`ifdef SHIFTER_CARRY_EN
        check("ror1_carry", 64'(carry_out), 64'd1);
`endif

        do_op(64'h1234, 6'd0, 2'b11, lat);
        check("amt0_lat", 64'(lat), 64'd1);
        check("amt0_data", out_data, 64'h1234);
`ifdef SHIFTER_CARRY_EN
        check("amt0_carry", 64'(carry_out), 64'd0);
`endif

        do_op(64'h0123_4567_89AB_CDEF, 6'd12, 2'b11, lat);
        check("ror12_lat", 64'(lat), 64'd2);
        check("ror12_data", out_data, 64'hDEF0_1234_5678_9ABC);

        do_op(64'h4000_0000_0000_0000, 6'd62, 2'b10, lat);
        check("asr62_lat", 64'(lat), 64'd8);
        check("asr62_data", out_data, 64'h1);

        do_op(64'h8000_0000_0000_0001, 6'd1, 2'b00, lat);
        check("lsl1_data", out_data, 64'h2);
`ifdef SHIFTER_CARRY_EN
        check("lsl1_carry", 64'(carry_out), 64'd1);
`endif
        do_op(64'h1, 6'd63, 2'b00, lat);
        check("lsl63_lat", 64'(lat), 64'd8);
        check("lsl63_data", out_data, 64'h8000_0000_0000_0000);
        @(posedge clk);
        #1 check("hold_after_hs_ready", 64'(in_ready), 64'd1);
        check("hold_after_hs_data", out_data, 64'h8000_0000_0000_0000);

        out_ready = 1'b0;
        do_op(64'h3, 6'd4, 2'b00, lat);
        check("bp_data0", out_data, 64'h30);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 64'hFFFF;
            in_amt   = 6'd1;
            in_mode  = 2'b01;
            @(posedge clk);
            #1;
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_data", out_data, 64'h30);
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 check("bp_release_ready", 64'(in_ready), 64'd1);
        check("bp_release_valid", 64'(out_valid), 64'd0);

        do_op(64'h5, 6'd40, 2'b00, lat);
        check("lsl40_data", out_data, 64'h0500_0000_0000);
        do_op(64'hFF, 6'd40, 2'b00, lat);
        lat = 0;
        do_op_partial: begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 64'h5;
            in_amt   = 6'd40;
            in_mode  = 2'b00;
            @(posedge clk);
            #1 in_valid = 1'b0;
            repeat (2) @(posedge clk);
            #2 reset = 1'b1;
            #1;
            check("midrst_valid", 64'(out_valid), 64'd0);
            check("midrst_data", out_data, 64'd0);
            @(negedge clk) reset = 1'b0;
            #1 check("midrst_in_ready", 64'(in_ready), 64'd1);
        end

        do_op(64'h3, 6'd8, 2'b00, lat);
        check("post_rst_lat", 64'(lat), 64'd1);
        check("post_rst_data", out_data, 64'h300);

        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
